present_player_iter: RTL and testbench

Iterative, parametrised PRESENT-style bit-permutation engine with valid/ready handshakes on input and output. Applies the permutation layer P, or its inverse P⁻¹, a programmable number of times (0 to 2^CNT_BITS−1) to one WIDTH-bit word, one application per clock. It replaces the fixed 64-bit combinational PLayer in round-datapath and key-schedule experiments that need other state widths, decryption direction, or multi-round permutation testing.

---
 rtl/present_player_iter_if.sv | 27 ++
 rtl/present_player_iter.sv | 78 +++++++
 tb/tb_present_player_iter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/present_player_iter_if.sv
// Request/result bundle for present_player_iter: one valid/ready channel in,
// one valid/ready channel out.
interface present_player_iter_if #(
    parameter int WIDTH    = 64,
    parameter int CNT_BITS = 4
);
    // Both channels: a transfer happens on a rising edge where valid and ready
    // are both 1. The producer holds valid and its payload stable until that edge.
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data;
    logic                in_inverse;
    logic [CNT_BITS-1:0] in_count;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;

    modport master (
        output in_valid, in_data, in_inverse, in_count, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_inverse, in_count, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/present_player_iter.sv
// Iterative PRESENT-style bit permutation: applies P or P^-1 a programmed
// number of times to one word, one application per clock.
module present_player_iter #(
    parameter int WIDTH    = 64,
    parameter int CNT_BITS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    present_player_iter_if.slave   bus,
    output logic [1:0]             fsm_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [CNT_BITS-1:0] remaining_q, remaining_d;
    logic                inverse_q, inverse_d;
    logic [WIDTH-1:0]    p_fwd, p_inv;

    // P sends bit i to i*WIDTH/4 mod (WIDTH-1); since 4*(WIDTH/4) == 1 mod (WIDTH-1),
    // multiplying by 4 undoes it. The top bit is fixed under both.
    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_perm
        assign p_fwd[(i * (WIDTH / 4)) % (WIDTH - 1)] = data_q[i];
        assign p_inv[(4 * i) % (WIDTH - 1)]           = data_q[i];
    end
    assign p_fwd[WIDTH-1] = data_q[WIDTH-1];
    assign p_inv[WIDTH-1] = data_q[WIDTH-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            remaining_q <= '0;
            inverse_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            remaining_q <= remaining_d;
            inverse_q   <= inverse_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        remaining_d = remaining_q;
        inverse_d   = inverse_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d      = bus.in_data;
                    inverse_d   = bus.in_inverse;
                    remaining_d = bus.in_count;
                    state_d     = (bus.in_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                data_d      = inverse_q ? p_inv : p_fwd;
                remaining_d = remaining_q - 1'b1;
                if (remaining_q == CNT_BITS'(1)) state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags decode state only, so neither depends on the partner's signal.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = data_q;
    assign fsm_state     = state_q;
endmodule

// File: tb/tb_present_player_iter.sv
// Bench for present_player_iter: 64-bit and 16-bit instances driven by directed
// and random requests, checked against a gather/scatter permutation model.
module tb_present_player_iter;
    logic clk;
    logic reset;
    logic [1:0] st64, st16;
    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    present_player_iter_if #(.WIDTH(64), .CNT_BITS(4)) if64();
    present_player_iter_if #(.WIDTH(16), .CNT_BITS(4)) if16();

    present_player_iter #(.WIDTH(64), .CNT_BITS(4)) dut64 (
        .clk(clk), .reset(reset), .bus(if64), .fsm_state(st64));
    present_player_iter #(.WIDTH(16), .CNT_BITS(4)) dut16 (
        .clk(clk), .reset(reset), .bus(if16), .fsm_state(st16));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] model(input logic [63:0] x, input int w,
                                          input bit inv, input int n);
        logic [63:0] y, t;
        int pos;
        y = x;
        for (int r = 0; r < n; r++) begin
            t = y;
            y = '0;
            for (int i = 0; i < w - 1; i++) begin
                pos = (i * (w / 4)) % (w - 1);
                if (!inv) y[pos] = t[i];
                else      y[i]   = t[pos];
            end
            y[w-1] = t[w-1];
        end
        return y;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_in(input bit w16, input bit v, input logic [63:0] d,
                          input bit inv, input int cnt);
        if (w16) begin
            if16.in_valid = v; if16.in_data = d[15:0];
            if16.in_inverse = inv; if16.in_count = 4'(cnt);
        end else begin
            if64.in_valid = v; if64.in_data = d;
            if64.in_inverse = inv; if64.in_count = 4'(cnt);
        end
    endtask

    task automatic set_oready(input bit w16, input bit r);
        if (w16) if16.out_ready = r;
        else     if64.out_ready = r;
    endtask

    function automatic bit get_iready(input bit w16);
        return w16 ? if16.in_ready : if64.in_ready;
    endfunction

    function automatic bit get_ovalid(input bit w16);
        return w16 ? if16.out_valid : if64.out_valid;
    endfunction

    function automatic logic [63:0] get_odata(input bit w16);
        return w16 ? {48'b0, if16.out_data} : if64.out_data;
    endfunction

    // Issues one request, returns the first result seen and the number of
    // rising edges from acceptance to out_valid (40 means it never came).
    task automatic run_op(input bit w16, input logic [63:0] d, input bit inv,
                          input int cnt, input int hold,
                          output logic [63:0] res, output int lat);
        int waited = 0;
        while (!get_iready(w16) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        set_in(w16, 1'b1, d, inv, cnt);
        @(negedge clk);
        set_in(w16, 1'b0, '0, 1'b0, 0);
        lat = 1;
        while (!get_ovalid(w16) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = get_odata(w16);
        if (lat < 40) begin
            repeat (hold) @(negedge clk);
            set_oready(w16, 1'b1);
            @(negedge clk);
            set_oready(w16, 1'b0);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b0;
        set_in(0, 0, '0, 0, 0); set_in(1, 0, '0, 0, 0);
        set_oready(0, 0); set_oready(1, 0);
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            n_checks++;
            if (get_iready(w[0]) !== 1'b1) begin
                $display("FAIL reset_in_ready w16=%0d got %b want 1", w, get_iready(w[0])); n_fail++;
            end
            n_checks++;
            if (get_ovalid(w[0]) !== 1'b0) begin
                $display("FAIL reset_out_valid w16=%0d got %b want 0", w, get_ovalid(w[0])); n_fail++;
            end
            n_checks++;
            if (get_odata(w[0]) !== 64'h0) begin
                $display("FAIL reset_out_data w16=%0d got %h want 0", w, get_odata(w[0])); n_fail++;
            end
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        bit          w16;
        logic [63:0] d;
        bit          inv;
        int          cnt;
        logic [63:0] exp;
        int          lat;
    } dcase_t;

    task automatic test_directed;
        dcase_t cs[7];
        logic [63:0] res;
        int lat;
        cs[0] = '{0, 64'h0000000000000002, 0, 1, 64'h0000000000010000, 2};
        cs[1] = '{0, 64'h0000000000010000, 1, 1, 64'h0000000000000002, 2};
        cs[2] = '{0, 64'h8000000000000001, 1, 1, 64'h8000000000000001, 2};
        cs[3] = '{0, 64'h0123456789ABCDEF, 0, 3, 64'h0123456789ABCDEF, 4};
        cs[4] = '{0, 64'h0123456789ABCDEF, 0, 0, 64'h0123456789ABCDEF, 1};
        cs[5] = '{1, 64'h0000000000000002, 0, 1, 64'h0000000000000010, 2};
        cs[6] = '{1, 64'h0000000000000010, 1, 1, 64'h0000000000000002, 2};
        foreach (cs[k]) begin
            run_op(cs[k].w16, cs[k].d, cs[k].inv, cs[k].cnt, 0, res, lat);
            n_checks++;
            if (res !== cs[k].exp) begin
                $display("FAIL directed_data case %0d got %h want %h", k, res, cs[k].exp); n_fail++;
            end
            n_checks++;
            if (lat !== cs[k].lat) begin
                $display("FAIL directed_latency case %0d got %0d want %0d", k, lat, cs[k].lat); n_fail++;
            end
        end
    endtask

    task automatic test_random;
        logic [63:0] d, res, exp;
        bit w16, inv;
        int cnt, lat;
        for (int k = 0; k < 40; k++) begin
            w16 = 1'($urandom_range(0, 1));
            inv = 1'($urandom_range(0, 1));
            cnt = $urandom_range(0, 15);
            d   = {$urandom, $urandom};
            if (w16) d = d & 64'hFFFF;
            exp_q.push_back(model(d, w16 ? 16 : 64, inv, cnt));
            run_op(w16, d, inv, cnt, $urandom_range(0, 3), res, lat);
            exp = exp_q.pop_front();
            n_checks++;
            if (res !== exp) begin
                $display("FAIL random_data iter %0d w16=%0d inv=%0d cnt=%0d got %h want %h",
                         k, w16, inv, cnt, res, exp); n_fail++;
            end
            n_checks++;
            if (lat !== cnt + 1) begin
                $display("FAIL random_latency iter %0d got %0d want %0d", k, lat, cnt + 1); n_fail++;
            end
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] d, exp, d2;
        int waited = 0;
        d   = 64'hDEADBEEFCAFEF00D;
        exp = model(d, 64, 0, 2);
        set_in(0, 1, d, 0, 2);
        @(negedge clk);
        set_in(0, 0, '0, 0, 0);
        while (!get_ovalid(0) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        for (int c = 0; c < 5; c++) begin
            set_in(0, c[0], {$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
            @(negedge clk);
            n_checks++;
            if (get_ovalid(0) !== 1'b1 || get_iready(0) !== 1'b0 || get_odata(0) !== exp) begin
                $display("FAIL backpressure_hold cycle %0d valid=%b ready=%b data=%h want 1 0 %h",
                         c, get_ovalid(0), get_iready(0), get_odata(0), exp); n_fail++;
            end
        end
        set_in(0, 0, '0, 0, 0);
        set_oready(0, 1);
        @(negedge clk);
        set_oready(0, 0);
        n_checks++;
        if (get_iready(0) !== 1'b1 || get_ovalid(0) !== 1'b0) begin
            $display("FAIL backpressure_release ready=%b valid=%b want 1 0",
                     get_iready(0), get_ovalid(0)); n_fail++;
        end
        d2 = 64'h0F1E2D3C4B5A6978;
        set_in(0, 1, d2, 1, 0);
        @(negedge clk);
        set_in(0, 0, '0, 0, 0);
        n_checks++;
        if (get_ovalid(0) !== 1'b1 || get_odata(0) !== d2) begin
            $display("FAIL backpressure_next valid=%b data=%h want 1 %h",
                     get_ovalid(0), get_odata(0), d2); n_fail++;
        end
        set_oready(0, 1);
        @(negedge clk);
        set_oready(0, 0);
    endtask

    task automatic test_reset_mid_run;
        logic [63:0] res, d;
        int lat, seen;
        d = 64'hA5A5123400FF9876;
        set_in(0, 1, d, 0, 7);
        @(negedge clk);
        set_in(0, 0, '0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (get_iready(0) !== 1'b1 || get_ovalid(0) !== 1'b0 || get_odata(0) !== 64'h0) begin
            $display("FAIL midrun_reset ready=%b valid=%b data=%h want 1 0 0",
                     get_iready(0), get_ovalid(0), get_odata(0)); n_fail++;
        end
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (get_ovalid(0)) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            $display("FAIL midrun_no_result got %0d valid cycles want 0", seen); n_fail++;
        end
        run_op(0, d, 0, 7, 0, res, lat);
        n_checks++;
        if (res !== model(d, 64, 0, 7) || lat !== 8) begin
            $display("FAIL midrun_recover got %h lat %0d want %h lat 8",
                     res, lat, model(d, 64, 0, 7)); n_fail++;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset;
        test_directed;
        test_random;
        test_backpressure;
        test_reset_mid_run;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
